// File: rtl/wb_mem_arbiter_pkg.sv
// Shared Wishbone types and arbiter state encodings.
package wb_mem_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t OWN_I = 2'd1;
    localparam arb_state_t OWN_D = 2'd2;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        stb;
        logic        cyc;
    } wb_req_t;

endpackage

// File: rtl/wb_mem_arbiter.sv
// Two-master (fetch/data) to one-slave Wishbone arbiter.
// Ownership is held per cyc, data has priority, fetch is bounded against starvation, and a watchdog aborts hung transfers.
//   state | meaning
//   IDLE  | no owner, slave request outputs held at 0
//   OWN_I | fetch master owns the slave
//   OWN_D | data master owns the slave
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_adr_i,
    input  logic [31:0] i_dat_i,
    input  logic [3:0]  i_sel_i,
    input  logic        i_we_i,
    input  logic        i_stb_i,
    input  logic        i_cyc_i,
    output logic [31:0] i_dat_o,
    output logic        i_ack_o,
    output logic        i_err_o,
    output logic        i_rty_o,
    input  logic [31:0] d_adr_i,
    input  logic [31:0] d_dat_i,
    input  logic [3:0]  d_sel_i,
    input  logic        d_we_i,
    input  logic        d_stb_i,
    input  logic        d_cyc_i,
    output logic [31:0] d_dat_o,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic        d_rty_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    output logic [1:0]  grant_o
);

    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    // wd_cnt only has to hold TIMEOUT_CYCLES-1: the abort fires on the stalled cycle that would reach the limit
    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t      r_state;
    logic [SC_W-1:0] r_starve_cnt;
    logic [WD_W-1:0] r_wd_cnt;

    wb_req_t    w_i_req;
    wb_req_t    w_d_req;
    wb_req_t    w_own;
    arb_state_t w_state_nxt;
    logic       w_resp;
    logic       w_stall;
    logic       w_wd_abort;
    logic       w_rearb;
    logic       w_req_i;
    logic       w_req_d;

    assign w_i_req = '{adr: i_adr_i, dat: i_dat_i, sel: i_sel_i, we: i_we_i, stb: i_stb_i, cyc: i_cyc_i};
    assign w_d_req = '{adr: d_adr_i, dat: d_dat_i, sel: d_sel_i, we: d_we_i, stb: d_stb_i, cyc: d_cyc_i};

    always_comb begin
        w_own = '0;
        case (r_state)
            OWN_I:   w_own = w_i_req;
            OWN_D:   w_own = w_d_req;
            default: w_own = '0;
        endcase
    end

    assign w_resp     = s_ack_i | s_err_i | s_rty_i;
    assign w_stall    = w_own.stb & ~w_resp;
    assign w_wd_abort = (TIMEOUT_CYCLES != 0) && w_stall && (r_wd_cnt == WD_LAST);

    // An aborted owner is excluded from the re-arbitration as though it had dropped cyc
    always_comb begin
        w_req_i     = i_cyc_i & ~(w_wd_abort & (r_state == OWN_I));
        w_req_d     = d_cyc_i & ~(w_wd_abort & (r_state == OWN_D));
        w_rearb     = (r_state == IDLE) | ~w_own.cyc | w_wd_abort;
        w_state_nxt = r_state;
        if (w_rearb) begin
            if (w_req_i && w_req_d)
                w_state_nxt = (r_starve_cnt == SC_MAX) ? OWN_I : OWN_D;
            else if (w_req_i)
                w_state_nxt = OWN_I;
            else if (w_req_d)
                w_state_nxt = OWN_D;
            else
                w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_wd_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rearb && w_state_nxt == OWN_I)
                r_starve_cnt <= '0;
            else if (w_rearb && w_state_nxt == OWN_D && i_cyc_i && r_starve_cnt != SC_MAX)
                r_starve_cnt <= r_starve_cnt + SC_W'(1);
            if (TIMEOUT_CYCLES == 0 || w_wd_abort || !w_stall || w_state_nxt != r_state)
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    assign s_adr_o = w_own.adr;
    assign s_dat_o = w_own.dat;
    assign s_sel_o = w_own.sel;
    assign s_we_o  = w_own.we;
    assign s_stb_o = w_own.stb & ~w_wd_abort;
    assign s_cyc_o = w_own.cyc & ~w_wd_abort;

    assign i_dat_o = s_dat_i;
    assign d_dat_o = s_dat_i;
    assign i_ack_o = (r_state == OWN_I) & s_ack_i;
    assign i_err_o = (r_state == OWN_I) & (s_err_i | w_wd_abort);
    assign i_rty_o = (r_state == OWN_I) & s_rty_i;
    assign d_ack_o = (r_state == OWN_D) & s_ack_i;
    assign d_err_o = (r_state == OWN_D) & (s_err_i | w_wd_abort);
    assign d_rty_o = (r_state == OWN_D) & s_rty_i;

    assign grant_o = {r_state == OWN_D, r_state == OWN_I};

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_adr_i = '0, i_dat_i = '0;
    logic [3:0]  i_sel_i = '0;
    logic        i_we_i = 1'b0, i_stb_i = 1'b0, i_cyc_i = 1'b0;
    logic [31:0] i_dat_o;
    logic        i_ack_o, i_err_o, i_rty_o;
    logic [31:0] d_adr_i = '0, d_dat_i = '0;
    logic [3:0]  d_sel_i = '0;
    logic        d_we_i = 1'b0, d_stb_i = 1'b0, d_cyc_i = 1'b0;
    logic [31:0] d_dat_o;
    logic        d_ack_o, d_err_o, d_rty_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
    logic [1:0]  grant_o;

    int n_checks = 0;
    int n_err    = 0;

    wb_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_adr_i(i_adr_i), .i_dat_i(i_dat_i), .i_sel_i(i_sel_i), .i_we_i(i_we_i),
        .i_stb_i(i_stb_i), .i_cyc_i(i_cyc_i),
        .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_rty_o(i_rty_o),
        .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i), .d_we_i(d_we_i),
        .d_stb_i(d_stb_i), .d_cyc_i(d_cyc_i),
        .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_rty_o(d_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout: observed no end expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        s_dat_i = 32'h1234_5678;
        #2;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_s_stb", 32'(s_stb_o), 32'h0);
        chk("rst_s_adr", s_adr_o, 32'h0);
        chk("rst_i_ack", 32'(i_ack_o), 32'h0);
        chk("rst_d_err", 32'(d_err_o), 32'h0);
        chk("rst_i_dat", i_dat_o, 32'h1234_5678);
        chk("rst_d_dat", d_dat_o, 32'h1234_5678);
        chk("rst_starve", 32'(dut.r_starve_cnt), 32'h0);
        step();
        rst = 1'b0;
        step();

        // fetch-only transfer
        i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h8000_0000; #1;
        chk("f0_grant", 32'(grant_o), 32'h0);
        chk("f0_s_cyc", 32'(s_cyc_o), 32'h0);
        step();
        chk("f1_grant", 32'(grant_o), 32'h1);
        chk("f1_s_adr", s_adr_o, 32'h8000_0000);
        chk("f1_s_cyc", 32'(s_cyc_o), 32'h1);
        step();
        step();
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D; #1;
        chk("f3_i_ack", 32'(i_ack_o), 32'h1);
        chk("f3_d_ack", 32'(d_ack_o), 32'h0);
        chk("f3_d_dat", d_dat_o, 32'hCAFE_F00D);
        step();
        s_ack_i = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
        step();
        chk("f5_grant", 32'(grant_o), 32'h0);

        // simultaneous request: data first, fetch follows with no idle cycle
        i_cyc_i = 1'b1; i_stb_i = 1'b1;
        d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h0000_1000; d_we_i = 1'b1; d_dat_i = 32'h0000_AA55;
        step();
        chk("s1_grant", 32'(grant_o), 32'h2);
        chk("s1_s_adr", s_adr_o, 32'h0000_1000);
        chk("s1_s_we", 32'(s_we_o), 32'h1);
        chk("s1_s_dat", s_dat_o, 32'h0000_AA55);
        chk("s1_starve", 32'(dut.r_starve_cnt), 32'h1);
        step();
        s_ack_i = 1'b1; #1;
        chk("s2_d_ack", 32'(d_ack_o), 32'h1);
        chk("s2_i_ack", 32'(i_ack_o), 32'h0);
        step();
        s_ack_i = 1'b0; d_stb_i = 1'b0;
        step();
        step();
        d_cyc_i = 1'b0; d_we_i = 1'b0; #1;
        chk("s5_grant", 32'(grant_o), 32'h2);
        step();
        chk("s6_grant", 32'(grant_o), 32'h1);
        chk("s6_s_adr", s_adr_o, 32'h8000_0000);
        chk("s6_starve", 32'(dut.r_starve_cnt), 32'h0);
        s_ack_i = 1'b1; #1;
        chk("s6_i_ack", 32'(i_ack_o), 32'h1);
        step();
        s_ack_i = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
        step();
        chk("s8_grant", 32'(grant_o), 32'h0);

        // starvation: four contested data wins, the fifth contest goes to fetch
        for (int r = 1; r <= 4; r++) begin
            i_cyc_i = 1'b1; i_stb_i = 1'b1; d_cyc_i = 1'b1; d_stb_i = 1'b1;
            step();
            chk($sformatf("st%0d_grant", r), 32'(grant_o), 32'h2);
            i_cyc_i = 1'b0; i_stb_i = 1'b0; s_ack_i = 1'b1; #1;
            chk($sformatf("st%0d_d_ack", r), 32'(d_ack_o), 32'h1);
            step();
            d_cyc_i = 1'b0; d_stb_i = 1'b0; s_ack_i = 1'b0;
            step();
            chk($sformatf("st%0d_idle", r), 32'(grant_o), 32'h0);
            chk($sformatf("st%0d_cnt", r), 32'(dut.r_starve_cnt), 32'(r));
        end
        i_cyc_i = 1'b1; i_stb_i = 1'b1; d_cyc_i = 1'b1; d_stb_i = 1'b1;
        step();
        chk("st5_grant", 32'(grant_o), 32'h1);
        chk("st5_cnt", 32'(dut.r_starve_cnt), 32'h0);
        s_ack_i = 1'b1; #1;
        chk("st5_i_ack", 32'(i_ack_o), 32'h1);
        step();
        i_cyc_i = 1'b0; i_stb_i = 1'b0; s_ack_i = 1'b0;
        step();
        chk("st6_grant", 32'(grant_o), 32'h2);
        chk("st6_cnt", 32'(dut.r_starve_cnt), 32'h0);
        s_ack_i = 1'b1;
        step();
        s_ack_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
        step();
        chk("st7_idle", 32'(grant_o), 32'h0);

        // burst: fetch keeps the bus for the whole line while data waits
        i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h8000_0100;
        step();
        d_cyc_i = 1'b1; d_stb_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i_stb_i = k[0];
            s_ack_i = k[0];
            #1;
            chk($sformatf("b%0d_grant", k), 32'(grant_o), 32'h1);
            chk($sformatf("b%0d_i_ack", k), 32'(i_ack_o), 32'(k % 2));
            chk($sformatf("b%0d_d_ack", k), 32'(d_ack_o), 32'h0);
            step();
        end
        s_ack_i = 1'b0; i_stb_i = 1'b0; i_cyc_i = 1'b0; #1;
        chk("b9_grant", 32'(grant_o), 32'h1);
        step();
        chk("b10_grant", 32'(grant_o), 32'h2);
        s_ack_i = 1'b1; #1;
        chk("b10_d_ack", 32'(d_ack_o), 32'h1);
        step();
        s_ack_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
        step();
        chk("b12_idle", 32'(grant_o), 32'h0);

        // watchdog: fetch stalls, error on the 8th stalled cycle, data takes over
        i_cyc_i = 1'b1; i_stb_i = 1'b1;
        step();
        d_cyc_i = 1'b1; d_stb_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            #1;
            chk($sformatf("w%0d_i_err", k), 32'(i_err_o), 32'h0);
            chk($sformatf("w%0d_s_cyc", k), 32'(s_cyc_o), 32'h1);
            step();
        end
        #1;
        chk("w8_i_err", 32'(i_err_o), 32'h1);
        chk("w8_d_err", 32'(d_err_o), 32'h0);
        chk("w8_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("w8_s_stb", 32'(s_stb_o), 32'h0);
        chk("w8_grant", 32'(grant_o), 32'h1);
        step();
        chk("w9_grant", 32'(grant_o), 32'h2);
        chk("w9_d_err", 32'(d_err_o), 32'h0);
        i_cyc_i = 1'b0; i_stb_i = 1'b0; s_ack_i = 1'b1; #1;
        chk("w9_d_ack", 32'(d_ack_o), 32'h1);
        chk("w9_i_err", 32'(i_err_o), 32'h0);
        step();
        s_ack_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
        step();
        chk("w11_idle", 32'(grant_o), 32'h0);

        // async reset in the middle of a data transfer
        d_cyc_i = 1'b1; d_stb_i = 1'b1;
        step();
        chk("r1_grant", 32'(grant_o), 32'h2);
        chk("r1_s_cyc", 32'(s_cyc_o), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("r1_rst_grant", 32'(grant_o), 32'h0);
        chk("r1_rst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("r1_rst_s_stb", 32'(s_stb_o), 32'h0);
        step();
        rst = 1'b0; #1;
        chk("r2_grant", 32'(grant_o), 32'h0);
        step();
        chk("r3_grant", 32'(grant_o), 32'h2);
        chk("r3_s_cyc", 32'(s_cyc_o), 32'h1);
        s_ack_i = 1'b1;
        step();
        s_ack_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
        step();
        chk("r5_idle", 32'(grant_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
